// File: rtl/ram_access_ctrl.sv
// ram_access_ctrl: single-transaction front end for a single-port synchronous
// RAM. It accepts one read or write request at a time, issues it to the RAM,
// and returns read data through a valid/ready response port.
module ram_access_ctrl #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst_n,
   // request port
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   // write completion
   output logic              wr_done,
   // read response port
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   // RAM side
   output logic              ram_we,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_data,
   input  logic [DATA_W-1:0] ram_q
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      CAPT  = 3'd3,
      RESP  = 3'd4
   } state_e;

   state_e              state_q, state_d;
   logic                we_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                wr_done_q, wr_done_d;
   logic                accept;

   // Next-state decode and request handshake; requests are only seen in IDLE.
   always_comb begin
      state_d   = state_q;
      req_ready = 1'b0;
      accept    = 1'b0;
      unique case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept  = 1'b1;
               state_d = req_we ? WRITE : READ;
            end
         end
         WRITE:   state_d = IDLE;
         READ:    state_d = CAPT;
         CAPT:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Read-data capture and write-completion pulse next values.
   always_comb begin
      rdata_d   = rdata_q;
      wr_done_d = 1'b0;
      if (state_q == CAPT) begin
         rdata_d = ram_q;
      end
      if (state_q == WRITE) begin
         wr_done_d = 1'b1;
      end
   end

   // State, request latches and response registers; reset aborts any transaction.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         wr_done_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         rdata_q   <= rdata_d;
         wr_done_q <= wr_done_d;
         if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   // RAM drive: the latched request is always presented; the write strobe is
   // gated by rst_n so that a reset landing in WRITE never reaches the array.
   always_comb begin
      ram_we   = rst_n && (state_q == WRITE) && we_q;
      ram_addr = addr_q;
      ram_data = wdata_q;
   end

   assign rsp_valid = (state_q == RESP);
   assign rsp_rdata = rdata_q;
   assign wr_done   = wr_done_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Directed bench for ram_access_ctrl with a behavioural model of the
// downstream single-port RAM (address registered when not writing).
module tb_ram_access_ctrl;

   localparam int unsigned DW = 8;
   localparam int unsigned AW = 6;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic          req_we;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          wr_done;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_data;
   logic [DW-1:0] ram_q;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   always #5 clk = ~clk;

   ram_access_ctrl #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .wr_done   (wr_done),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_rdata (rsp_rdata),
      .ram_we    (ram_we),
      .ram_addr  (ram_addr),
      .ram_data  (ram_data),
      .ram_q     (ram_q)
   );

   // RAM model
   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW-1:0] raddr_q = '0;
   initial for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_data;
      else        raddr_q       <= ram_addr;
   end
   assign ram_q = mem[raddr_q];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // Called one step after an edge with the DUT in IDLE.
   task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid = 1'b1; req_we = 1'b1; req_addr = a; req_wdata = d;
      tick;                                   // accept edge E0
      chk("wr_ready_busy", req_ready, 0);
      chk("wr_ram_we",     ram_we,    1);
      chk("wr_ram_addr",   ram_addr,  a);
      chk("wr_ram_data",   ram_data,  d);
      chk("wr_done_early", wr_done,   0);
      req_valid = 1'b0;
      tick;                                   // commit edge E0+1
      chk("wr_mem",        mem[a],    d);
      chk("wr_done_pulse", wr_done,   1);
      chk("wr_we_off",     ram_we,    0);
      chk("wr_ready_back", req_ready, 1);
      tick;
      chk("wr_done_once",  wr_done,   0);
   endtask

   task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] exp,
                          input int unsigned hold, input logic early);
      req_valid = 1'b1; req_we = 1'b0; req_addr = a; req_wdata = 8'h00;
      rsp_ready = early;                      // early rsp_ready must be ignored
      tick;                                   // accept edge E0 -> READ
      chk("rd_ready_busy", req_ready, 0);
      chk("rd_ram_we",     ram_we,    0);
      chk("rd_ram_addr",   ram_addr,  a);
      chk("rd_valid_e1",   rsp_valid, 0);
      req_valid = 1'b0;
      tick;                                   // E0+1 -> CAPT
      chk("rd_valid_e2",   rsp_valid, 0);
      chk("rd_ready_capt", req_ready, 0);
      tick;                                   // E0+2 -> RESP, sampled high at E0+3
      chk("rd_valid",      rsp_valid, 1);
      chk("rd_data",       rsp_rdata, exp);
      for (int unsigned i = 0; i < hold; i++) begin
         // stray write request while busy: must not be accepted
         req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h3F; req_wdata = 8'hFF;
         tick;
         chk("hold_valid", rsp_valid, 1);
         chk("hold_data",  rsp_rdata, exp);
         chk("hold_ready", req_ready, 0);
         chk("hold_we",    ram_we,    0);
         chk("hold_addr",  ram_addr,  a);
         req_valid = 1'b0;
      end
      rsp_ready = 1'b1;
      tick;                                   // handshake edge -> IDLE
      chk("rd_valid_drop", rsp_valid, 0);
      chk("rd_idle_ready", req_ready, 1);
      chk("rd_addr_held",  ram_addr,  a);
      rsp_ready = 1'b0;
   endtask

   typedef struct {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;   // write data, or expected read data
      int unsigned   hold;
      logic          early;
   } vec_t;

   vec_t vecs [9];

   initial begin
      vecs[0] = '{1'b1, 6'h3F, 8'hA5, 0, 1'b0};
      vecs[1] = '{1'b0, 6'h3F, 8'hA5, 0, 1'b0};   // read right after write
      vecs[2] = '{1'b1, 6'h00, 8'h11, 0, 1'b0};
      vecs[3] = '{1'b1, 6'h01, 8'h22, 0, 1'b0};
      vecs[4] = '{1'b0, 6'h00, 8'h11, 0, 1'b0};
      vecs[5] = '{1'b0, 6'h01, 8'h22, 0, 1'b1};   // rsp_ready high before RESP
      vecs[6] = '{1'b1, 6'h05, 8'h5A, 0, 1'b0};
      vecs[7] = '{1'b0, 6'h05, 8'h5A, 4, 1'b0};   // consumer stalls 4 cycles
      vecs[8] = '{1'b0, 6'h3F, 8'hA5, 0, 1'b0};   // stray writes left 0x3F alone

      rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0;
      req_wdata = '0; rsp_ready = 1'b0;
      tick; tick;
      chk("rst_ready",   req_ready, 1);
      chk("rst_valid",   rsp_valid, 0);
      chk("rst_wr_done", wr_done,   0);
      chk("rst_ram_we",  ram_we,    0);
      chk("rst_rdata",   rsp_rdata, 0);
      chk("rst_addr",    ram_addr,  0);
      chk("rst_wdata",   ram_data,  0);
      rst_n = 1'b1;
      tick;
      chk("idle_ready",  req_ready, 1);
      chk("idle_valid",  rsp_valid, 0);

      for (int i = 0; i < 9; i++) begin
         if (vecs[i].we) do_write(vecs[i].addr, vecs[i].data);
         else            do_read(vecs[i].addr, vecs[i].data, vecs[i].hold, vecs[i].early);
      end

      // Reset while in CAPT: response discarded.
      do_write(6'h07, 8'h77);
      req_valid = 1'b1; req_we = 1'b0; req_addr = 6'h07;
      tick;                                   // -> READ
      req_valid = 1'b0;
      tick;                                   // -> CAPT
      rst_n = 1'b0;
      tick;
      chk("capt_rst_valid", rsp_valid, 0);
      chk("capt_rst_ready", req_ready, 1);
      chk("capt_rst_rdata", rsp_rdata, 0);
      chk("capt_rst_addr",  ram_addr,  0);
      rst_n = 1'b1;
      tick;
      chk("capt_rst_valid2", rsp_valid, 0);
      chk("capt_rst_mem",    mem[7],    8'h77);

      // Reset while in WRITE: write suppressed.
      req_valid = 1'b1; req_we = 1'b1; req_addr = 6'h07; req_wdata = 8'hEE;
      tick;                                   // -> WRITE
      req_valid = 1'b0;
      chk("wr_rst_we_pre", ram_we, 1);
      rst_n = 1'b0;
      #1;
      chk("wr_rst_we_gated", ram_we, 0);
      tick;
      chk("wr_rst_mem",     mem[7],    8'h77);
      chk("wr_rst_wr_done", wr_done,   0);
      chk("wr_rst_ready",   req_ready, 1);
      rst_n = 1'b1;
      tick;
      chk("wr_rst_wr_done2", wr_done, 0);
      do_read(6'h07, 8'h77, 0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram_access_ctrl.md
RAM_ACCESS_CTRL -- requirements
Module: ram_access_ctrl

Interface
REQ-001 Parameter DATA_W, default 8: data width; SHALL match the downstream single-port RAM data width.
REQ-002 Parameter ADDR_W, default 6: address width; 2**ADDR_W words (64).
REQ-003 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_we  input  1  1 = write, 0 = read.
REQ-008 req_addr  input  ADDR_W  request address.
REQ-009 req_wdata  input  DATA_W  write data.
REQ-010 wr_done  output  1  one-cycle pulse when a write has been committed to RAM.
REQ-011 rsp_valid  output  1  read data available.
REQ-012 rsp_ready  input  1  consumer accepts read data.
REQ-013 rsp_rdata  output  DATA_W  registered read data.
REQ-014 ram_we  output  1  RAM write enable.
REQ-015 ram_addr  output  ADDR_W  RAM address.
REQ-016 ram_data  output  DATA_W  RAM write data.
REQ-017 ram_q  input  DATA_W  RAM read data; the RAM registers the address on clk when ram_we=0, and ram_q is combinational from that registered address.

Function
REQ-018 FSM states SHALL be IDLE, WRITE, READ, CAPT and RESP; the reset state SHALL be IDLE.
REQ-019 req_ready SHALL be 1 in IDLE only, so at most one transaction is in flight.
REQ-020 Handshake: a request SHALL be accepted on an edge where req_valid=1 and req_ready=1, latching req_we, req_addr and req_wdata into internal registers.
REQ-021 Request inputs SHALL be ignored whenever req_ready=0.
REQ-022 IDLE SHALL go to WRITE on an accepted write and to READ on an accepted read; otherwise it SHALL stay in IDLE.
REQ-023 WRITE SHALL last exactly 1 cycle:
- ram_we=1, ram_addr=latched address, ram_data=latched data.
- Next state IDLE.
- wr_done=1 in the cycle after WRITE.
REQ-024 READ SHALL last exactly 1 cycle with ram_we=0 and ram_addr=latched address, so the RAM registers the address at the end of the cycle; next state CAPT.
REQ-025 CAPT SHALL last exactly 1 cycle: rsp_rdata <= ram_q at its closing edge; next state RESP.
REQ-026 RESP SHALL hold rsp_valid=1 with rsp_rdata stable until an edge with rsp_ready=1, then go to IDLE.
REQ-027 Read latency: accept at edge E0 SHALL give rsp_valid=1 from edge E0+3.
REQ-028 Write latency: accept at edge E0 SHALL commit the write at edge E0+1, with req_ready=1 again after E0+1.
REQ-029 In IDLE, READ, CAPT and RESP: ram_we SHALL be 0, ram_addr SHALL be the latched address, and ram_data SHALL be the latched data (no X on outputs).
REQ-030 Boundary cases SHALL behave as follows:
- Addresses 0 and 2**ADDR_W-1 SHALL be handled identically; no address arithmetic, no wrap logic.
- Back-to-back requests SHALL be separated by at least one IDLE cycle.
- A read of an address written by the immediately preceding transaction SHALL return the new data.
- rsp_ready asserted outside RESP SHALL be ignored.

Reset
REQ-031 With rst_n=0 at an edge:
- State SHALL become IDLE.
- rsp_valid=0, wr_done=0, rsp_rdata=0.
- Latched address and data SHALL be 0.
REQ-032 ram_we SHALL be forced to 0 combinationally while rst_n=0, so no RAM write occurs in a reset cycle.
REQ-033 Reset mid-transaction SHALL abort it: a pending read response is discarded and an unissued write is not performed.

Verification
REQ-034 Reset then idle -> req_ready=1, rsp_valid=0, wr_done=0, ram_we=0, rsp_rdata=0x00.
REQ-035 Write 0xA5 to 0x3F at E0, then read 0x3F -> ram_we=1 only in the cycle after E0, wr_done pulses once, and the read returns rsp_rdata=0xA5 with rsp_valid rising 3 edges after read acceptance.
REQ-036 Write 0x11 to 0x00, write 0x22 to 0x01, read 0x00, read 0x01 -> responses 0x11 then 0x22; req_ready=0 throughout each transaction.
REQ-037 Read 0x05 (holding 0x5A) with rsp_ready=0 for 4 cycles -> rsp_valid and rsp_rdata=0x5A stay stable, req_valid pulses are ignored, and IDLE follows the edge where rsp_ready=1.
REQ-038 rst_n=0 asserted while in CAPT, and separately while in WRITE -> no rsp_valid, no RAM write, IDLE on the next cycle, and RAM contents unchanged.
